// File: rtl/mano_sequence_control.sv
// Instruction-cycle sequencer: start/stop flop, 3-bit sequence counter, one-hot timing,
// and the captured instruction word with its opcode/indirect/address decodes.
module mano_sequence_control (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] ir_in,
  output logic [7:0]  T,
  output logic [7:0]  D,
  output logic        I,
  output logic [15:0] B,
  output logic        run,
  output logic [2:0]  sc
);

  logic        run_q, run_d;
  logic [2:0]  sc_q, sc_d;
  logic [15:0] ir_q, ir_d;

  logic [7:0] t_dec;
  logic [7:0] d_dec;
  logic       hlt;
  logic       clr;

  always_comb begin
    t_dec = run_q ? (8'd1 << sc_q) : 8'd0;
    d_dec = 8'd1 << ir_q[14:12];
    // HLT is the register-reference instruction with only bit 0 of the address field set.
    hlt   = d_dec[7] & ~ir_q[15] & t_dec[3] & ir_q[0];
    clr   = (d_dec[7] & t_dec[3])
          | ((d_dec[0] | d_dec[1] | d_dec[2] | d_dec[5]) & t_dec[5])
          | ((d_dec[3] | d_dec[4]) & t_dec[4])
          | (d_dec[6] & t_dec[6])
          | t_dec[7];
  end

  always_comb begin
    run_d = run_q;
    sc_d  = sc_q;
    ir_d  = ir_q;
    if (run_q) begin
      if (t_dec[2]) begin
        ir_d = ir_in;
      end
      if (hlt) begin
        run_d = 1'b0;
        sc_d  = 3'd0;
      end else if (clr) begin
        sc_d = 3'd0;
      end else begin
        sc_d = sc_q + 3'd1;
      end
    end else begin
      sc_d = 3'd0;
      if (start) begin
        run_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q <= 1'b0;
      sc_q  <= 3'd0;
      ir_q  <= 16'h0000;
    end else begin
      run_q <= run_d;
      sc_q  <= sc_d;
      ir_q  <= ir_d;
    end
  end

  assign T   = t_dec;
  assign D   = d_dec;
  assign I   = ir_q[15];
  assign B   = {4'b0000, ir_q[11:0]};
  assign run = run_q;
  assign sc  = sc_q;

endmodule

// File: tb/tb_mano_sequence_control.sv
// Directed bench for mano_sequence_control: per-cycle timing expectations are queued
// when stimulus is applied and popped as each cycle is sampled.
module tb_mano_sequence_control;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] ir_in;
  logic [7:0]  T;
  logic [7:0]  D;
  logic        I;
  logic [15:0] B;
  logic        run;
  logic [2:0]  sc;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] t;
    logic       run;
    logic [2:0] sc;
  } exp_t;

  exp_t exp_q[$];

  mano_sequence_control dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .ir_in (ir_in),
    .T     (T),
    .D     (D),
    .I     (I),
    .B     (B),
    .run   (run),
    .sc    (sc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input logic [7:0] t, input logic r, input logic [2:0] s);
    exp_t e;
    e.t   = t;
    e.run = r;
    e.sc  = s;
    exp_q.push_back(e);
  endtask

  task automatic check_state(input string tag);
    exp_t e;
    checks++;
    assert (exp_q.size() != 0) else begin
      errors++;
      $error("FAIL %s_queue observed=empty expected=entry", tag);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, "_T"}, {8'h00, T}, {8'h00, e.t});
    chk({tag, "_run"}, {15'h0, run}, {15'h0, e.run});
    chk({tag, "_sc"}, {13'h0, sc}, {13'h0, e.sc});
  endtask

  task automatic push_halted(input int n);
    for (int k = 0; k < n; k++) push_exp(8'h00, 1'b0, 3'd0);
  endtask

  task automatic check_halted(input string tag, input int n);
    push_halted(n);
    for (int k = 0; k < n; k++) begin
      tick();
      check_state(tag);
    end
  endtask

  // Steps through one instruction from T0; the caller sets ir_in (and start if halted).
  task automatic run_instr(input string tag, input int len, input logic [7:0] ed,
                           input logic ei, input logic [15:0] eb, input bit scramble,
                           input int start_at, input int rst_at);
    for (int k = 0; k < len; k++) push_exp(8'd1 << k, 1'b1, 3'(k));
    for (int k = 0; k < len; k++) begin
      tick();
      start = 1'b0;
      check_state(tag);
      if (k >= 3) begin
        chk({tag, "_D"}, {8'h00, D}, {8'h00, ed});
        chk({tag, "_I"}, {15'h0, I}, {15'h0, ei});
        chk({tag, "_B"}, B, eb);
        if (scramble) ir_in = 16'($urandom);
      end
      if (k == start_at) start = 1'b1;
      if (k == rst_at) rst = 1'b1;
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b1;
    ir_in = 16'h0000;

    // Reset held with start high
    push_halted(2);
    tick();
    check_state("rst0");
    tick();
    check_state("rst1");
    chk("rst_D", {8'h00, D}, 16'h0001);
    chk("rst_I", {15'h0, I}, 16'h0000);
    chk("rst_B", B, 16'h0000);
    rst   = 1'b0;
    start = 1'b0;
    check_halted("idle", 2);

    // AND, then CLA back-to-back, then HLT
    ir_in = 16'h0123;
    start = 1'b1;
    run_instr("and", 6, 8'h01, 1'b0, 16'h0123, 1'b0, -1, -1);
    ir_in = 16'h7800;
    run_instr("cla", 4, 8'h80, 1'b0, 16'h0800, 1'b0, -1, -1);
    ir_in = 16'h7001;
    run_instr("hlt", 4, 8'h80, 1'b0, 16'h0001, 1'b0, -1, -1);
    check_halted("halted", 3);
    chk("halted_D", {8'h00, D}, 16'h0080);

    // Restart into ISZ with ir_in disturbed after capture
    ir_in = 16'hE050;
    start = 1'b1;
    run_instr("isz", 7, 8'h40, 1'b1, 16'h0050, 1'b1, -1, -1);

    // STA with a start pulse while running
    ir_in = 16'h3010;
    run_instr("sta", 5, 8'h08, 1'b0, 16'h0010, 1'b0, 2, -1);

    // Start coincident with HLT
    ir_in = 16'h7001;
    run_instr("hltstart", 4, 8'h80, 1'b0, 16'h0001, 1'b0, 3, -1);
    push_exp(8'h00, 1'b0, 3'd0);
    tick();
    start = 1'b0;
    check_state("hltstart_end");
    check_halted("hltstart_idle", 2);

    // ADD interrupted by reset at T4
    ir_in = 16'h1234;
    start = 1'b1;
    run_instr("add", 5, 8'h02, 1'b0, 16'h0234, 1'b0, -1, 4);
    push_exp(8'h00, 1'b0, 3'd0);
    tick();
    rst = 1'b0;
    check_state("add_rst");
    chk("add_rst_D", {8'h00, D}, 16'h0001);
    chk("add_rst_B", B, 16'h0000);
    check_halted("add_rst_idle", 2);

    chk("queue_drained", 16'(exp_q.size()), 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
